// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial receive stage.
package serial_rx_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_e;

   localparam int unsigned CH_NUM_DEF   = 8;
   localparam int unsigned MAX_BITS_DEF = 128;
   localparam int unsigned CNT_W        = 16;
   localparam int unsigned ERR_W        = 3;

   // rx_err bit positions: {ovf, chg, multi}
   localparam int unsigned ERR_OVF   = 2;
   localparam int unsigned ERR_CHG   = 1;
   localparam int unsigned ERR_MULTI = 0;

endpackage

// File: rtl/serial_rx_shift.sv
// Deserializer core: MSB-first shift register, saturating bit counter,
// overflow flag. Optional macro SERIAL_RX_GRAY_DECODE_EN decodes Gray bits
// as they are stored.
module serial_rx_shift
   import serial_rx_pkg::*;
#(
   parameter int unsigned MAX_BITS = MAX_BITS_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                shift_i,
   input  logic                bit_i,
   output logic [MAX_BITS-1:0] shreg_o,
   output logic [CNT_W-1:0]    count_o,
   output logic                ovf_o
);

   logic [MAX_BITS-1:0] shreg_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                ovf_q;
   logic                store_bit_c;

   // Bit actually written into the register for a non-first bit
`ifdef SERIAL_RX_GRAY_DECODE_EN
   assign store_bit_c = bit_i ^ shreg_q[0];
`else
   assign store_bit_c = bit_i;
`endif

   // First bit loads fresh; later bits shift in until the counter saturates
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         shreg_q <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (start_i) begin
         shreg_q <= MAX_BITS'(bit_i);
         cnt_q   <= CNT_W'(1);
         ovf_q   <= 1'b0;
      end else if (shift_i) begin
         if (cnt_q < CNT_W'(MAX_BITS)) begin
            shreg_q <= {shreg_q[MAX_BITS-2:0], store_bit_c};
            cnt_q   <= cnt_q + CNT_W'(1);
         end else begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign shreg_o = shreg_q;
   assign count_o = cnt_q;
   assign ovf_o   = ovf_q;

endmodule

// File: rtl/serial_rx_stage.sv
// Multi-channel serial frame receiver with one-entry output buffer.
// Optional macro SERIAL_RX_GRAY_DECODE_EN enables Gray decode in the shifter.
module serial_rx_stage
   import serial_rx_pkg::*;
#(
   parameter int unsigned CH_NUM   = CH_NUM_DEF,
   parameter int unsigned MAX_BITS = MAX_BITS_DEF
) (
   input  logic                clk_out16x,
   input  logic                rst,
   input  logic [CH_NUM-1:0]   din_ch,
   input  logic [CH_NUM-1:0]   dvld_ch,
   output logic [MAX_BITS-1:0] rx_data,
   output logic [CNT_W-1:0]    rx_count,
   output logic [CH_NUM-1:0]   rx_ch,
   output logic [ERR_W-1:0]    rx_err,
   output logic                rx_valid,
   input  logic                rx_ready,
   output logic                rx_overrun
);

   state_e              state_q;
   logic [CH_NUM-1:0]   ch_q;
   logic                chg_q;
   logic                multi_q;

   logic [MAX_BITS-1:0] data_q;
   logic [CNT_W-1:0]    count_q;
   logic [CH_NUM-1:0]   rxch_q;
   logic [ERR_W-1:0]    err_q;
   logic                valid_q;
   logic                overrun_q;

   logic                any_vld_c;
   logic                start_c;
   logic                shift_c;
   logic                done_c;
   logic [CH_NUM-1:0]   sel_c;
   logic                bit_c;
   logic [MAX_BITS-1:0] shreg_c;
   logic [CNT_W-1:0]    cnt_c;
   logic                ovf_c;
   logic [MAX_BITS-1:0] aligned_c;
   logic [ERR_W-1:0]    frame_err_c;

   assign any_vld_c = |dvld_ch;
   assign start_c   = (state_q == IDLE) && any_vld_c;
   assign shift_c   = (state_q == RECV) && any_vld_c;
   assign done_c    = (state_q == RECV) && !any_vld_c;

   // The first bit is sampled on the channels being latched that same edge
   assign sel_c = (state_q == IDLE) ? dvld_ch : ch_q;
   assign bit_c = |(din_ch & sel_c);

   serial_rx_shift #(
      .MAX_BITS (MAX_BITS)
   ) u_shift (
      .clk_i   (clk_out16x),
      .rst_i   (rst),
      .start_i (start_c),
      .shift_i (shift_c),
      .bit_i   (bit_c),
      .shreg_o (shreg_c),
      .count_o (cnt_c),
      .ovf_o   (ovf_c)
   );

   // Left-align the stored bits so the first bit lands at the MSB
   assign aligned_c = shreg_c << (CNT_W'(MAX_BITS) - cnt_c);

   // Assemble the per-frame error vector
   always_comb begin
      frame_err_c            = '0;
      frame_err_c[ERR_OVF]   = ovf_c;
      frame_err_c[ERR_CHG]   = chg_q;
      frame_err_c[ERR_MULTI] = multi_q;
   end

   // Frame FSM: latch channel set at start, track multi/chg flags
   always_ff @(posedge clk_out16x or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
         chg_q   <= 1'b0;
         multi_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_vld_c) begin
                  state_q <= RECV;
                  ch_q    <= dvld_ch;
                  chg_q   <= 1'b0;
                  multi_q <= (dvld_ch & (dvld_ch - CH_NUM'(1))) != '0;
               end
            end
            RECV: begin
               if (any_vld_c) begin
                  if (dvld_ch != ch_q) begin
                     chg_q <= 1'b1;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // One-entry output buffer; a completion into a full, stalled buffer is dropped
   always_ff @(posedge clk_out16x or posedge rst) begin
      if (rst) begin
         data_q    <= '0;
         count_q   <= '0;
         rxch_q    <= '0;
         err_q     <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= 1'b0;
         if (done_c && (!valid_q || rx_ready)) begin
            data_q  <= aligned_c;
            count_q <= cnt_c;
            rxch_q  <= ch_q;
            err_q   <= frame_err_c;
            valid_q <= 1'b1;
         end else if (done_c) begin
            overrun_q <= 1'b1;
         end else if (valid_q && rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx_data    = data_q;
   assign rx_count   = count_q;
   assign rx_ch      = rxch_q;
   assign rx_err     = err_q;
   assign rx_valid   = valid_q;
   assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_serial_rx_stage.sv
// Scoreboard bench for serial_rx_stage: frames are queued as issued, a
// negedge monitor compares whatever the output buffer presents.
module tb_serial_rx_stage;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   din;
   logic [7:0]   dvld;
   logic [127:0] rx_data;
   logic [15:0]  rx_count;
   logic [7:0]   rx_ch;
   logic [2:0]   rx_err;
   logic         rx_valid;
   logic         rx_ready;
   logic         rx_overrun;

   typedef struct {
      logic [127:0] data;
      logic [15:0]  count;
      logic [7:0]   ch;
      logic [2:0]   err;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   ovr_seen = 0;

   always #5 clk = ~clk;

   serial_rx_stage dut (
      .clk_out16x (clk),
      .rst        (rst),
      .din_ch     (din),
      .dvld_ch    (dvld),
      .rx_data    (rx_data),
      .rx_count   (rx_count),
      .rx_ch      (rx_ch),
      .rx_err     (rx_err),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_overrun (rx_overrun)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   // Monitor: compare the buffered frame every cycle it is shown, pop on handshake
   always @(negedge clk) begin
      if (!rst && rx_valid) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame act=%h exp=none", rx_data);
         end else begin
            chk("rx_data",  rx_data,            sbq[0].data);
            chk("rx_count", 128'(rx_count),     128'(sbq[0].count));
            chk("rx_ch",    128'(rx_ch),        128'(sbq[0].ch));
            chk("rx_err",   128'(rx_err),       128'(sbq[0].err));
            if (rx_ready) sbq.delete(0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rx_overrun) ovr_seen++;
   end

   // Drive one frame; bits[n-1] goes first. Mask m1 replaces m0 from bit sw on.
   task automatic send(input logic [7:0] m0, input logic [7:0] m1, input int sw,
                       input logic [255:0] bits, input int n, input bit expect_frame);
      exp_t e;
      int   nb;
      logic b, s, prev;
      nb     = (n > 128) ? 128 : n;
      prev   = 1'b0;
      e.data = '0;
      for (int k = 0; k < nb; k++) begin
         b = bits[n-1-k];
`ifdef SERIAL_RX_GRAY_DECODE_EN
         s = (k == 0) ? b : (b ^ prev);
`else
         s = b;
`endif
         prev = s;
         e.data[127-k] = s;
      end
      e.count = 16'(nb);
      e.ch    = m0;
      e.err   = {(n > 128), ((sw < n) && (m1 != m0)), ($countones(m0) > 1)};
      if (expect_frame) sbq.push_back(e);
      for (int k = 0; k < n; k++) begin
         b    = bits[n-1-k];
         dvld = (k >= sw) ? m1 : m0;
         din  = b ? m0 : ~m0;
         @(posedge clk); #1;
      end
      dvld = '0;
      din  = '0;
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_data"},    rx_data,              '0);
      chk({tag, "_count"},   128'(rx_count),       '0);
      chk({tag, "_ch"},      128'(rx_ch),          '0);
      chk({tag, "_err"},     128'(rx_err),         '0);
      chk({tag, "_valid"},   128'(rx_valid),       '0);
      chk({tag, "_overrun"}, 128'(rx_overrun),     '0);
   endtask

   initial begin
      rst      = 1'b1;
      din      = '0;
      dvld     = '0;
      rx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      // Ch3, 16 bits 0xA5F0; rx_valid must show one cycle after the last bit
      send(8'h04, 8'h04, 16, 256'(16'hA5F0), 16, 1'b1);
      @(posedge clk); #1;
      chk("latency_valid", 128'(rx_valid), 128'(1));
      repeat (2) @(posedge clk); #1;

      // Ch1, 130 bits: saturates at 128 with ovf
      send(8'h01, 8'h01, 130, 256'({2'b10, {4{32'hDEADBEEF}}}), 130, 1'b1);
      repeat (3) @(posedge clk); #1;

      // Two ch5 frames, one-cycle gap, consumer stalled: second is dropped
      rx_ready = 1'b0;
      send(8'h10, 8'h10, 8, 256'(8'h3C), 8, 1'b1);
      @(posedge clk); #1;
      send(8'h10, 8'h10, 8, 256'(8'h81), 8, 1'b0);
      @(posedge clk); #1;
      repeat (4) @(posedge clk); #1;
      chk("overrun_count", 128'(ovr_seen), 128'(1));
      rx_ready = 1'b1;
      repeat (3) @(posedge clk); #1;

      // Multi-channel start, then mid-frame channel switch
      send(8'h03, 8'h03, 12, 256'(12'hB2D), 12, 1'b1);
      @(posedge clk); #1;
      send(8'h02, 8'h08, 5, 256'(16'h5AC3), 16, 1'b1);
      repeat (3) @(posedge clk); #1;

      // Accept of a held frame on the same edge as the next completion
      rx_ready = 1'b0;
      send(8'h40, 8'h40, 6, 256'(6'b101101), 6, 1'b1);
      @(posedge clk); #1;
      send(8'h40, 8'h40, 10, 256'(10'h2F1), 10, 1'b1);
      rx_ready = 1'b1;
      repeat (4) @(posedge clk); #1;
      chk("overrun_no_new", 128'(ovr_seen), 128'(1));

      // Reset 40 bits into a 64-bit frame, then a clean 8-bit frame
      for (int k = 0; k < 40; k++) begin
         dvld = 8'h20;
         din  = 8'($urandom);
         @(posedge clk); #1;
      end
      rst  = 1'b1;
      dvld = '0;
      din  = '0;
      repeat (2) @(posedge clk); #1;
      chk_zero_outputs("midrst");
      rst = 1'b0;
      @(posedge clk); #1;
      send(8'h20, 8'h20, 8, 256'(8'h96), 8, 1'b1);
      repeat (3) @(posedge clk); #1;

      // Gray-coded input pattern
      send(8'h80, 8'h80, 8, 256'(8'hC0), 8, 1'b1);
      repeat (3) @(posedge clk); #1;

      for (int i = 0; i < 50 && sbq.size() != 0; i++) @(posedge clk);
      #1;
      chk("queue_drained", 128'(sbq.size()), '0);
      chk("final_valid", 128'(rx_valid), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_rx_stage.md
SERIAL_RX_STAGE -- requirements
Module: serial_rx_stage

Interface
REQ-001 SHALL have parameter CH_NUM, default 8, number of serial channels.
REQ-002 SHALL have parameter MAX_BITS, default 128, deserializer width.
REQ-003 SHALL have port clk_out16x  input  1  bit clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port din_ch  input  CH_NUM  serial data per channel; bit i = channel i+1.
REQ-006 SHALL have port dvld_ch  input  CH_NUM  data-valid per channel.
REQ-007 SHALL have port rx_data  output  MAX_BITS  received frame, first bit at MSB, unfilled LSBs zero.
REQ-008 SHALL have port rx_count  output  16  number of bits stored in rx_data (1..MAX_BITS).
REQ-009 SHALL have port rx_ch  output  CH_NUM  dvld_ch vector latched at frame start.
REQ-010 SHALL have port rx_err  output  3  {ovf, chg, multi}, valid with rx_valid.
REQ-011 SHALL have port rx_valid  output  1  output buffer holds a frame.
REQ-012 SHALL have port rx_ready  input  1  consumer accepts frame.
REQ-013 SHALL have port rx_overrun  output  1  one-cycle pulse: completed frame dropped.

Function
REQ-014 SHALL implement FSM IDLE/RECV; frame = consecutive cycles with |dvld_ch == 1.
REQ-015 IDLE -> RECV on |dvld_ch; same edge latches dvld_ch into channel register, stores first bit, bit count = 1.
REQ-016 Data bit of a cycle SHALL be |(din_ch & latched channel); shifted in MSB-first.
REQ-017 RECV, |dvld_ch == 1: shift bit in, count +1; count saturates at MAX_BITS, further bits discarded, ovf set.
REQ-018 RECV, |dvld_ch == 0: frame complete, return to IDLE on that edge; idle-gap of exactly one cycle between frames SHALL be supported.
REQ-019 Frame start with >1 dvld_ch bit set SHALL set multi; frame still received.
REQ-020 dvld_ch differing from latched channel while nonzero in RECV SHALL set chg; sampling continues on latched channel.
REQ-021 On completion, stored bits SHALL be left-aligned so bit k of a count-N frame sits at rx_data[MAX_BITS-1-k], rx_data[MAX_BITS-1-N:0] = 0.
REQ-022 Completed frame SHALL load one-entry output buffer; rx_valid rises on the edge sampling |dvld_ch == 0 (latency: rx_valid visible 1 cycle after last valid bit cycle).
REQ-023 rx_data/rx_count/rx_ch/rx_err SHALL be stable while rx_valid && !rx_ready.
REQ-024 rx_valid && rx_ready SHALL clear buffer next edge; completion on same edge SHALL load new frame (rx_valid stays 1).
REQ-025 Completion while buffer full and rx_ready == 0 SHALL drop new frame, pulse rx_overrun one cycle, keep buffered frame.
REQ-026 Receiving SHALL continue regardless of output buffer state (no backpressure on serial side).

Reset
REQ-027 rst SHALL force IDLE, clear shift/count/channel registers, any in-flight frame discarded.
REQ-028 Reset values: rx_data=0, rx_count=0, rx_ch=0, rx_err=0, rx_valid=0, rx_overrun=0.
REQ-029 First frame after rst deassertion SHALL require |dvld_ch rising from IDLE; a frame already in progress at deassertion is received from its next bit, flagged normally.

Configuration
REQ-030 Macro SERIAL_RX_GRAY_DECODE_EN defined: stored bits SHALL be Gray-to-binary decoded on the fly (stored bit = incoming bit XOR previously stored bit, first bit unchanged).
REQ-031 Macro undefined: raw received bits stored; no decode logic present.

Structure
REQ-032 Package serial_rx_pkg SHALL hold state enum (IDLE, RECV), CH_NUM/MAX_BITS defaults, rx_err bit index constants.
REQ-033 Single sub-module serial_rx_shift SHALL contain shift register, bit counter, saturation and optional Gray decode; FSM, error flags and output buffer in top.

Verification
REQ-034 Ch3 frame, 16 bits 0xA5F0, rx_ready=1 -> rx_valid 1 cycle after last bit, rx_data[127:112]=0xA5F0, rest 0, rx_count=16, rx_ch=8'h04, rx_err=0.
REQ-035 Ch1 frame 130 bits -> rx_count=128, rx_err=3'b100.
REQ-036 Two ch5 frames of 8 bits, 1-cycle gap, rx_ready=0 -> first held, rx_overrun pulses once at second completion.
REQ-037 Frame with dvld_ch=8'h03 at start -> rx_err=3'b001, rx_ch=8'h03; frame switching ch2->ch4 mid-frame -> rx_err=3'b010.
REQ-038 rst asserted at bit 40 of 64-bit frame -> all outputs 0, no rx_valid; next 8-bit frame received correctly.
REQ-039 With SERIAL_RX_GRAY_DECODE_EN, 8-bit input 8'b1100_0000 -> rx_data[127:120]=8'b1000_0000; without, 8'b1100_0000.
